// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT loader constants, sample type and bit-reverse helper.
package fft_pkg;
  localparam int DATA_W = 6;
  localparam int N = 8;
  localparam int LOG2N = 3;
  typedef struct packed {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
  } sample_t;
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] k);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = k[LOG2N-1-i];
    return r;
  endfunction
endpackage

// File: rtl/fft_input_loader_if.sv
// fft_input_loader_if: sample stream in, parallel frame out, both valid/ready.
interface fft_input_loader_if;
  import fft_pkg::*;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_re;
  logic [DATA_W-1:0] in_im;
  logic              out_valid;
  logic              out_ready;
  logic [N*DATA_W-1:0] out_re;
  logic [N*DATA_W-1:0] out_im;
  modport master (output in_valid, in_re, in_im, out_ready, input in_ready, out_valid, out_re, out_im);
  modport slave (input in_valid, in_re, in_im, out_ready, output in_ready, out_valid, out_re, out_im);
endinterface

// File: rtl/fft_frame_bank.sv
// fft_frame_bank: one N-entry re/im register bank with slot write and flat read.
module fft_frame_bank
  import fft_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [LOG2N-1:0]    addr,
  input  sample_t             din,
  output logic [N*DATA_W-1:0] re,
  output logic [N*DATA_W-1:0] im
);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      re <= '0;
      im <= '0;
    end else if (we) begin
      re[addr*DATA_W +: DATA_W] <= din.re;
      im[addr*DATA_W +: DATA_W] <= din.im;
    end
endmodule

// File: rtl/fft_input_loader.sv
// fft_input_loader: ping-pong frame assembler for the 8-point FFT; BITREV_EN selects bit-reversed slot order.
module fft_input_loader
  import fft_pkg::*;
(
  input logic clk,
  input logic rst,
  fft_input_loader_if.slave bus
);
  logic [1:0] full;
  logic wb, rb, acc, xfer, last;
  logic [LOG2N-1:0] cnt, slot;
  logic [N*DATA_W-1:0] re0, im0, re1, im1;
  sample_t din;
  assign bus.in_ready  = !full[wb];
  assign bus.out_valid = full[rb];
  assign acc  = bus.in_valid && bus.in_ready;
  assign xfer = bus.out_valid && bus.out_ready;
  assign last = cnt == LOG2N'(N-1);
  assign din  = '{re: bus.in_re, im: bus.in_im};
`ifdef BITREV_EN
  assign slot = bitrev(cnt);
`else
  assign slot = cnt;
`endif
  fft_frame_bank u_bank0 (.clk(clk), .rst(rst), .we(acc && !wb), .addr(slot), .din(din), .re(re0), .im(im0));
  fft_frame_bank u_bank1 (.clk(clk), .rst(rst), .we(acc && wb), .addr(slot), .din(din), .re(re1), .im(im1));
  assign bus.out_re = rb ? re1 : re0;
  assign bus.out_im = rb ? im1 : im0;
  // accept and transfer always touch different banks, so set and clear never collide
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      full <= '0;
      wb   <= 1'b0;
      rb   <= 1'b0;
      cnt  <= '0;
    end else begin
      full <= (full & ~{xfer && rb, xfer && !rb}) | {acc && last && wb, acc && last && !wb};
      cnt  <= cnt + LOG2N'(acc);
      wb   <= wb ^ (acc && last);
      rb   <= rb ^ xfer;
    end
endmodule
